// File: rtl/mul_arbiter_ctrl.sv
// Round-robin arbiter and sequencer for a shared combinational multiplier:
// accepts one requester's operands, waits LATENCY cycles, holds the product until consumed.
module mul_arbiter_ctrl #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic [WIDTH-1:0]   mul_x,
    output logic [WIDTH-1:0]   mul_y,
    input  logic [2*WIDTH-1:0] mul_z,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_hi,
    output logic [WIDTH-1:0]   rsp_lo,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("mul_arbiter_ctrl: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] count;
    logic       last_grant;
    logic       grant0;
    logic       grant1;

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high.
    // Ready may depend combinationally on valid; valid must not depend on ready.
    // Operands are sampled only on that edge; the response is held until rsp_valid & rsp_ready.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = (state == IDLE) & grant0;
        req1_ready = (state == IDLE) & grant1;
        busy       = (state != IDLE);
        dbg_state  = state;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant0 | grant1) state_nxt = CALC;
            CALC: if (count == 4'd0) state_nxt = RESP;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mul_x      <= '0;
            mul_y      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_hi     <= '0;
            rsp_lo     <= '0;
            count      <= 4'd0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        mul_x      <= req0_a;
                        mul_y      <= req0_b;
                        rsp_id     <= 1'b0;
                        last_grant <= 1'b0;
                        count      <= CNT_INIT;
                    end else if (grant1) begin
                        mul_x      <= req1_a;
                        mul_y      <= req1_b;
                        rsp_id     <= 1'b1;
                        last_grant <= 1'b1;
                        count      <= CNT_INIT;
                    end
                end
                CALC: begin
                    // Operands stay put; the multiplier output is trusted only once count runs out.
                    if (count == 4'd0) begin
                        rsp_hi    <= mul_z[2*WIDTH-1:WIDTH];
                        rsp_lo    <= mul_z[WIDTH-1:0];
                        rsp_valid <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter_ctrl.sv
// Directed bench for mul_arbiter_ctrl: LATENCY=2 instance for arbitration/backpressure/reset,
// LATENCY=1 instance for operand hold and short settle.
module tb_mul_arbiter_ctrl;
    localparam int W = 32;

    // clock / reset
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=2 instance
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, mul_x, mul_y, rsp_hi, rsp_lo;
    logic [2*W-1:0] mul_z;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [1:0]   dbg_state;
    logic signed [2*W-1:0] sx, sy;

    assign sx    = $signed(mul_x);
    assign sy    = $signed(mul_y);
    assign mul_z = sx * sy;

    mul_arbiter_ctrl #(.WIDTH(W), .LATENCY(2)) dut (
        .clk(clk), .clr(clr),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .busy(busy), .dbg_state(dbg_state)
    );

    // LATENCY=1 instance
    logic         l1_req0_valid, l1_req0_ready, l1_req1_valid, l1_req1_ready;
    logic [W-1:0] l1_req0_a, l1_req0_b, l1_req1_a, l1_req1_b, l1_mul_x, l1_mul_y, l1_rsp_hi, l1_rsp_lo;
    logic [2*W-1:0] l1_mul_z;
    logic         l1_rsp_valid, l1_rsp_ready, l1_rsp_id, l1_busy;
    logic [1:0]   l1_dbg_state;
    logic signed [2*W-1:0] l1_sx, l1_sy;

    assign l1_sx    = $signed(l1_mul_x);
    assign l1_sy    = $signed(l1_mul_y);
    assign l1_mul_z = l1_sx * l1_sy;

    mul_arbiter_ctrl #(.WIDTH(W), .LATENCY(1)) dut_l1 (
        .clk(clk), .clr(clr),
        .req0_valid(l1_req0_valid), .req0_ready(l1_req0_ready), .req0_a(l1_req0_a), .req0_b(l1_req0_b),
        .req1_valid(l1_req1_valid), .req1_ready(l1_req1_ready), .req1_a(l1_req1_a), .req1_b(l1_req1_b),
        .mul_x(l1_mul_x), .mul_y(l1_mul_y), .mul_z(l1_mul_z),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_id(l1_rsp_id),
        .rsp_hi(l1_rsp_hi), .rsp_lo(l1_rsp_lo), .busy(l1_busy), .dbg_state(l1_dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: {id, hi, lo} in acceptance order
    logic [2*W:0] exp_q[$];

    always @(negedge clk) begin
        if (clr && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", {rsp_id, rsp_hi, rsp_lo}, '0);
            end else begin
                check("sb_rsp", {rsp_id, rsp_hi, rsp_lo}, exp_q.pop_front());
            end
        end
        if (clr) begin
            check("one_ready", 65'(req0_ready & req1_ready), '0);
            check("ready_busy", 65'(busy & (req0_ready | req1_ready)), '0);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        step();
        step();
        clr = 1'b1;
    endtask

    task automatic wait_ready(input bit id);
        int n = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(id ? "wait_rdy1" : "wait_rdy0", 65'(id ? req1_ready : req0_ready), 65'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 65'(exp_q.size()), '0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req0_valid = 0; req0_a = '0; req0_b = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0;
        rsp_ready  = 0;
        l1_req0_valid = 0; l1_req0_a = '0; l1_req0_b = '0;
        l1_req1_valid = 0; l1_req1_a = '0; l1_req1_b = '0;
        l1_rsp_ready  = 0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rv", 65'(rsp_valid), '0);
        check("rst_busy", 65'(busy), '0);
        check("rst_state", 65'(dbg_state), '0);
        check("rst_mulxy", 65'({mul_x, mul_y}), '0);
        check("rst_rsp", {rsp_id, rsp_hi, rsp_lo}, '0);
        step();
        clr = 1'b1;

        // single request: -3 * 7 = -21
        rsp_ready = 1; req0_valid = 1; req0_a = 32'hFFFFFFFD; req0_b = 32'd7;
        @(negedge clk);
        check("t1_rdy0", 65'(req0_ready), 65'd1);
        check("t1_rdy1", 65'(req1_ready), '0);
        exp_q.push_back({1'b0, 64'hFFFFFFFF_FFFFFFEB});
        step();
        req0_valid = 0; req0_a = '0; req0_b = '0;
        @(negedge clk);
        check("t1_busy", 65'(busy), 65'd1);
        check("t1_state", 65'(dbg_state), 65'd1);
        check("t1_mulx", 65'(mul_x), 65'h0FFFFFFFD);
        check("t1_muly", 65'(mul_y), 65'd7);
        check("t1_rv_t0", 65'(rsp_valid), '0);
        step(); @(negedge clk);
        check("t1_rv_t1", 65'(rsp_valid), '0);
        step(); @(negedge clk);
        check("t1_rv_t2", 65'(rsp_valid), 65'd1);
        check("t1_rsp", {rsp_id, rsp_hi, rsp_lo}, {1'b0, 64'hFFFFFFFF_FFFFFFEB});
        step(); @(negedge clk);
        check("t1_busy_done", 65'(busy), '0);
        check("t1_rv_done", 65'(rsp_valid), '0);

        // tie arbitration from fresh reset
        step();
        do_reset();
        exp_q.push_back({1'b0, 64'd6});
        exp_q.push_back({1'b1, 64'd30});
        exp_q.push_back({1'b0, 64'd6});
        exp_q.push_back({1'b1, 64'd30});
        req0_valid = 1; req0_a = 32'd2; req0_b = 32'd3;
        req1_valid = 1; req1_a = 32'd5; req1_b = 32'd6;
        rsp_ready = 1;
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 60) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        check("t2_drain", 65'(exp_q.size()), '0);
        step();
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        check("t2_idle", 65'(busy), '0);

        // backpressure: -1 * -1 = 1, req1 waiting meanwhile
        rsp_ready = 0;
        step();
        req0_valid = 1; req0_a = 32'hFFFFFFFF; req0_b = 32'hFFFFFFFF;
        wait_ready(0);
        exp_q.push_back({1'b0, 64'd1});
        step();
        req0_valid = 0;
        req1_valid = 1; req1_a = 32'd3; req1_b = 32'd4;
        begin
            int n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("t3_rv", 65'(rsp_valid), 65'd1);
        repeat (5) begin
            @(negedge clk);
            check("t3_hold", {rsp_id, rsp_hi, rsp_lo}, {1'b0, 64'd1});
            check("t3_rv_hold", 65'(rsp_valid), 65'd1);
            check("t3_rdy1", 65'(req1_ready), '0);
            check("t3_busy", 65'(busy), 65'd1);
        end
        exp_q.push_back({1'b1, 64'd12});
        step();
        rsp_ready = 1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("t3_idle", 65'(busy), '0);
        check("t3_rdy1_idle", 65'(req1_ready), 65'd1);
        step();
        req1_valid = 0;
        wait_drain();

        // extremes
        req1_valid = 1; req1_a = 32'h80000000; req1_b = 32'h80000000;
        wait_ready(1);
        exp_q.push_back({1'b1, 64'h40000000_00000000});
        step();
        req1_valid = 0;
        wait_drain();
        req0_valid = 1; req0_a = 32'h7FFFFFFF; req0_b = 32'hFFFFFFFF;
        wait_ready(0);
        exp_q.push_back({1'b0, 64'hFFFFFFFF_80000001});
        step();
        req0_valid = 0;
        wait_drain();

        // reset mid-CALC
        req0_valid = 1; req0_a = 32'd5; req0_b = 32'd5;
        wait_ready(0);
        step();
        req0_valid = 0;
        step();
        clr = 1'b0;
        #1;
        check("t5_mulxy", 65'({mul_x, mul_y}), '0);
        check("t5_busy", 65'(busy), '0);
        check("t5_rv", 65'(rsp_valid), '0);
        check("t5_rsp", {rsp_id, rsp_hi, rsp_lo}, '0);
        step();
        step();
        clr = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t5_norsp", 65'(rsp_valid), '0);
        end
        step();
        req0_valid = 1; req0_a = 32'd9; req0_b = 32'd9;
        req1_valid = 1; req1_a = 32'd1; req1_b = 32'd1;
        @(negedge clk);
        check("t5_rdy0", 65'(req0_ready), 65'd1);
        check("t5_rdy1", 65'(req1_ready), '0);
        exp_q.push_back({1'b0, 64'd81});
        step();
        req0_valid = 0; req1_valid = 0;
        wait_drain();

        // LATENCY=1 with operand change right after accept
        l1_rsp_ready = 1; l1_req0_valid = 1; l1_req0_a = 32'd6; l1_req0_b = 32'd7;
        @(negedge clk);
        check("t6_rdy", 65'(l1_req0_ready), 65'd1);
        step();
        l1_req0_valid = 0; l1_req0_a = 32'd100; l1_req0_b = 32'd100;
        @(negedge clk);
        check("t6_mulx", 65'(l1_mul_x), 65'd6);
        check("t6_muly", 65'(l1_mul_y), 65'd7);
        check("t6_rv_t0", 65'(l1_rsp_valid), '0);
        step(); @(negedge clk);
        check("t6_rv_t1", 65'(l1_rsp_valid), 65'd1);
        check("t6_rsp", {l1_rsp_id, l1_rsp_hi, l1_rsp_lo}, {1'b0, 64'd42});
        step(); @(negedge clk);
        check("t6_busy_done", 65'(l1_busy), '0);

        check("sb_empty", 65'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
